// File: rtl/alu_reg_pkg.sv
// ============================================================================
// Module      : alu_reg_pkg
// Description : Shared opcode encodings and default widths for the
//               logic-unit / register-file datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_reg_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : Parameterized register array, one synchronous write port,
//               one asynchronous read port, synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data
);

    localparam int C_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem_q [C_DEPTH];
    logic [DATA_W-1:0] w_mem_d [C_DEPTH];

    // Clear wins over a simultaneous write.
    always_comb begin
        w_mem_d = r_mem_q;
        if (rst) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                w_mem_d[i] = '0;
            end
        end else if (we) begin
            w_mem_d[write_addr] = write_data;
        end
    end

    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

    assign read_data = r_mem_q[read_addr];

endmodule

`default_nettype wire

// File: rtl/alu_reg_integration.sv
// ============================================================================
// Module      : alu_reg_integration
// Description : 2-bit-opcode bitwise logic unit whose result is captured in
//               an 8-entry register file with a combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_reg_integration
    import alu_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [1:0]        opcode,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data
);

    logic [DATA_W-1:0] w_alu_result;

    always_comb begin
        w_alu_result = '0;
        case (opcode)
            OP_AND:  w_alu_result = A & B;
            OP_OR:   w_alu_result = A | B;
            OP_NAND: w_alu_result = ~(A & B);
            OP_NOR:  w_alu_result = ~(A | B);
            default: w_alu_result = '0;
        endcase
    end

    reg_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_reg_file (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .write_addr (write_addr),
        .write_data (w_alu_result),
        .read_addr  (read_addr),
        .read_data  (read_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_alu_reg_integration.sv
// ============================================================================
// Module      : tb_alu_reg_integration
// Description : Directed and randomized self-checking bench for
//               alu_reg_integration against a behavioural array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_reg_integration;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [7:0] A;
    logic [7:0] B;
    logic [1:0] opcode;
    logic [2:0] write_addr;
    logic [2:0] read_addr;
    logic [7:0] read_data;

    logic [7:0] model [8];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    alu_reg_integration dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .A          (A),
        .B          (B),
        .opcode     (opcode),
        .write_addr (write_addr),
        .read_addr  (read_addr),
        .read_data  (read_data)
    );

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            case (op)
                2'd0: r[i] = a[i] && b[i];
                2'd1: r[i] = a[i] || b[i];
                2'd2: r[i] = !(a[i] && b[i]);
                default: r[i] = !(a[i] || b[i]);
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    // Apply one clock edge with the given controls, then advance the model.
    task automatic step(input logic r, input logic w, input logic [7:0] a,
                        input logic [7:0] b, input logic [1:0] op, input logic [2:0] wa);
        rst = r; we = w; A = a; B = b; opcode = op; write_addr = wa;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 8; i++) model[i] = 8'h00;
        end else if (w) begin
            model[wa] = ref_alu(a, b, op);
        end
        rst = 1'b0; we = 1'b0;
        // Scramble inputs between edges; they must have no effect.
        A = 8'($urandom); B = 8'($urandom); opcode = 2'($urandom); write_addr = 3'($urandom);
    endtask

    task automatic read_check(input string tag, input logic [2:0] addr);
        read_addr = addr;
        #1;
        check(tag, read_data, model[addr]);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [1:0] rop;
        logic [2:0] rwa;
        rst = 1'b1; we = 1'b0; A = 8'h00; B = 8'h00; opcode = 2'b00;
        write_addr = 3'd0; read_addr = 3'd0;

        step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 3'd0);
        for (int i = 0; i < 8; i++) begin
            read_addr = 3'(i);
            #1;
            check("reset_read", read_data, 8'h00);
        end

        step(1'b0, 1'b1, 8'b10010101, 8'b11001100, 2'b00, 3'd1);
        read_addr = 3'd1; #1; check("and_e1", read_data, 8'b10000100);
        step(1'b0, 1'b1, 8'b01101010, 8'b11001100, 2'b01, 3'd2);
        read_addr = 3'd2; #1; check("or_e2", read_data, 8'b11101110);
        read_addr = 3'd1; #1; check("e1_hold", read_data, 8'b10000100);
        step(1'b0, 1'b1, 8'b10010101, 8'b11001100, 2'b10, 3'd3);
        read_addr = 3'd3; #1; check("nand_e3", read_data, 8'b01111011);
        step(1'b0, 1'b1, 8'b01010011, 8'b11001100, 2'b11, 3'd4);
        read_addr = 3'd4; #1; check("nor_e4", read_data, 8'b00100000);

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 2'($urandom), 3'd4);
            read_addr = 3'd4; #1; check("we0_e4", read_data, 8'b00100000);
        end

        step(1'b1, 1'b1, 8'hFF, 8'hFF, 2'b01, 3'd2);
        for (int i = 0; i < 8; i++) begin
            read_addr = 3'(i);
            #1;
            check("rst_over_we", read_data, 8'h00);
        end

        // Same-address read during a write: old value before edge, new after.
        step(1'b0, 1'b1, 8'h3C, 8'h0F, 2'b01, 3'd5);
        read_addr = 3'd5;
        rst = 1'b0; we = 1'b1; A = 8'hF0; B = 8'h0F; opcode = 2'b00; write_addr = 3'd5;
        #1;
        check("rw_old", read_data, 8'h3F);
        @(posedge clk);
        #1;
        model[5] = 8'h00;
        we = 1'b0;
        check("rw_new", read_data, 8'h00);

        for (int n = 0; n < 300; n++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 2'($urandom);
            rwa = 3'($urandom);
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), ra, rb, rop, rwa);
            read_check("rand_read", 3'($urandom));
            if (n % 50 == 49) begin
                for (int i = 0; i < 8; i++) read_check("rand_sweep", 3'(i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
